// File: rtl/alu_dispatch_1210084.sv
// Sequencing front end for the multifunction ALU: accepts one request, starts the
// selected function unit, waits for its done (or a timeout) and returns the result.
module alu_dispatch_1210084 #(
    parameter int SIZE    = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_sel,
    input  logic [SIZE-1:0]       req_a,
    input  logic [SIZE-1:0]       req_b,
    output logic [SIZE-1:0]       fu_a,
    output logic [SIZE-1:0]       fu_b,
    output logic [7:0]            fu_start,
    input  logic [7:0]            fu_done,
    input  logic [8*(SIZE+2)-1:0] fu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [SIZE+1:0]       rsp_result,
    output logic                  rsp_err,
    output logic [3:0]            rsp_sel
);

    localparam int RW = SIZE + 2;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [2:0]      unit;
    logic            done_hit;
    logic            last_cycle;
    logic [RW-1:0]   slice;

    // rsp_sel doubles as the in-flight unit index; only legal selects reach ISSUE/WAIT.
    assign unit       = rsp_sel[2:0];
    assign done_hit   = fu_done[unit];
    assign slice      = fu_result[unit*RW +: RW];
    assign last_cycle = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_valid) state_nxt = req_sel[3] ? RESP : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done_hit || last_cycle) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign fu_start  = (state == ISSUE) ? (8'd1 << unit) : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            fu_a       <= '0;
            fu_b       <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            rsp_sel    <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        rsp_sel <= req_sel;
                        fu_a    <= req_a;
                        fu_b    <= req_b;
                        if (req_sel[3]) begin
                            rsp_result <= '0;
                            rsp_err    <= 1'b1;
                        end
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    // A done on the final allowed cycle still wins over the timeout.
                    if (done_hit) begin
                        rsp_result <= slice;
                        rsp_err    <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (last_cycle) begin
                            rsp_result <= '0;
                            rsp_err    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_dispatch_1210084.sv
// Directed bench for alu_dispatch_1210084 with SIZE=3, TIMEOUT=15.
module tb_alu_dispatch_1210084;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_sel;
    logic [2:0]  req_a;
    logic [2:0]  req_b;
    logic [2:0]  fu_a;
    logic [2:0]  fu_b;
    logic [7:0]  fu_start;
    logic [7:0]  fu_done;
    logic [39:0] fu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_result;
    logic        rsp_err;
    logic [3:0]  rsp_sel;

    int n_checks = 0;
    int n_pass   = 0;

    alu_dispatch_1210084 #(.SIZE(3), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_a(req_a), .req_b(req_b),
        .fu_a(fu_a), .fu_b(fu_b), .fu_start(fu_start), .fu_done(fu_done),
        .fu_result(fu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .rsp_sel(rsp_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge while IDLE; returns at a negedge back in IDLE.
    // done_at: WAIT cycle (1-based) on which fu_done[sel] is raised, -1 = never.
    // hold: RESP cycles with rsp_ready low and a competing request driven.
    task automatic op(input string tag, input logic [3:0] sel, input logic [2:0] a,
                      input logic [2:0] b, input int done_at, input logic [7:0] other,
                      input logic [4:0] slice, input logic [4:0] exp_res,
                      input logic exp_err, input int exp_lat, input int hold);
        int lat;
        bit seen;
        chk({tag, "_req_ready"}, req_ready, 1);
        req_valid = 1; req_sel = sel; req_a = a; req_b = b;
        for (int k = 0; k < 8; k++)
            fu_result[k*5 +: 5] = (k == int'(sel[2:0])) ? slice : 5'(k + 16);
        fu_done = 8'd0;
        @(negedge clk);
        req_valid = 0;
        lat = 1;
        seen = 0;
        chk({tag, "_fu_a"}, fu_a, a);
        chk({tag, "_fu_b"}, fu_b, b);
        chk({tag, "_start"}, fu_start, (sel < 8) ? (8'd1 << sel[2:0]) : 8'd0);
        while (!seen && lat < 40) begin
            if (rsp_valid) seen = 1;
            else begin
                fu_done = other;
                // Done during ISSUE must be ignored; raise it there too when a done is expected.
                if (sel < 8 && done_at > 0 && (lat == 1 || lat - 1 == done_at))
                    fu_done[sel[2:0]] = 1'b1;
                @(negedge clk);
                lat++;
                if (lat == 2) chk({tag, "_start_off"}, fu_start, 0);
            end
        end
        fu_done = 8'd0;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, rsp_result, exp_res);
        chk({tag, "_err"}, rsp_err, exp_err);
        chk({tag, "_sel"}, rsp_sel, sel);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1; req_sel = 4'd6; req_a = 3'd7; req_b = 3'd7;
            @(negedge clk);
            chk({tag, "_bp_valid"}, rsp_valid, 1);
            chk({tag, "_bp_ready"}, req_ready, 0);
            chk({tag, "_bp_result"}, rsp_result, exp_res);
            chk({tag, "_bp_err"}, rsp_err, exp_err);
            chk({tag, "_bp_sel"}, rsp_sel, sel);
            chk({tag, "_bp_fu_a"}, fu_a, a);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk({tag, "_valid_drop"}, rsp_valid, 0);
        chk({tag, "_idle"}, req_ready, 1);
        chk({tag, "_hold_result"}, rsp_result, exp_res);
    endtask

    initial begin
        rst_n = 0; req_valid = 0; req_sel = 0; req_a = 0; req_b = 0;
        fu_done = 0; fu_result = 0; rsp_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_outputs", {fu_start, fu_a, fu_b, rsp_result, rsp_err, rsp_sel}, 0);
        rst_n = 1;
        @(negedge clk);

        // Reset asserted while waiting on unit 2
        req_valid = 1; req_sel = 4'd2; req_a = 3'd3; req_b = 3'd4;
        @(negedge clk);
        req_valid = 0;
        chk("mid_start", fu_start, 8'b0000_0100);
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_outputs", {fu_start, fu_a, fu_b, rsp_result, rsp_err, rsp_sel}, 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_start", fu_start, 0);
            chk("post_rst_valid", rsp_valid, 0);
        end

        op("legal",   4'd3,  3'd5, 3'd2,  2, 8'd0,        5'b00111, 5'd7,  1'b0,  4, 0);
        op("illegal", 4'd10, 3'd1, 3'd6, -1, 8'd0,        5'd0,     5'd0,  1'b1,  1, 0);
        op("wrong",   4'd1,  3'd4, 3'd3, -1, 8'b00000100, 5'h15,    5'd0,  1'b1, 17, 0);
        op("bndry",   4'd5,  3'd6, 3'd1, 15, 8'd0,        5'h1a,    5'h1a, 1'b0, 17, 5);
        op("pend",    4'd6,  3'd7, 3'd7,  1, 8'd0,        5'h0c,    5'h0c, 1'b0,  3, 0);
        op("max",     4'd7,  3'd2, 3'd3,  3, 8'b01111111, 5'h1f,    5'h1f, 1'b0,  5, 0);
        op("unit0",   4'd0,  3'd1, 3'd0,  1, 8'd0,        5'h11,    5'h11, 1'b0,  3, 0);
        op("ill15",   4'd15, 3'd3, 3'd3, -1, 8'd0,        5'd0,     5'd0,  1'b1,  1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_dispatch_1210084.md
Name: alu_dispatch_1210084

Overview:
- Sequencing front end for the multifunction ALU; the transmit-side counterpart to the 8-to-1 result selector.
- Accepts one operation request (function select plus two operands) through a valid/ready handshake. Sends the operands to the function units and pulses a one-hot start to the selected unit.
- Waits for that unit's done, captures its result slice, and returns result plus error flag through a second valid/ready handshake.
- One operation in flight at a time.

Parameters:
- SIZE, 3, operand width; result width is SIZE+2.
- TIMEOUT, 15, maximum WAIT cycles before error; legal range ≥ 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  block can accept a request.
- req_sel  in  4  function select; 0-7 valid, 8-15 illegal.
- req_a  in  SIZE  operand A.
- req_b  in  SIZE  operand B.
- fu_a  out  SIZE  registered operand A to all units.
- fu_b  out  SIZE  registered operand B to all units.
- fu_start  out  8  one-hot start pulse; bit k starts unit k.
- fu_done  in  8  per-unit done; bit k belongs to unit k.
- fu_result  in  8*(SIZE+2)  packed unit results; unit k occupies bits [k*(SIZE+2) +: SIZE+2].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  SIZE+2  captured result; 0 on error.
- rsp_err  out  1  1 = illegal select or timeout.
- rsp_sel  out  4  select of the operation being reported.

Behaviour:
- Clock and reset: clk is the single clock; rst_n is asynchronous, active-low.
- Reset (any state, including mid-operation): state IDLE; req_ready=1; fu_start=0; fu_a=fu_b=0; rsp_valid=0; rsp_result=0; rsp_err=0; rsp_sel=0; timeout counter=0. The in-flight operation is dropped and no start pulse is emitted after reset.
- States: IDLE, ISSUE, WAIT, RESP. req_ready=1 only in IDLE.
- IDLE, on req_valid=1:
  - Latch req_sel into rsp_sel and req_a/req_b into fu_a/fu_b.
  - If req_sel ≥ 8: go to RESP with rsp_result=0, rsp_err=1. No start pulse.
  - Otherwise: go to ISSUE.
- ISSUE (exactly one cycle): fu_start = 1<<sel, all other bits 0. Clear counter, go to WAIT.
- WAIT:
  - Only fu_done[sel] is sampled. Other done bits are ignored, as is done during the ISSUE cycle.
  - fu_done[sel]=1: capture the fu_result slice for sel into rsp_result, rsp_err=0, go to RESP.
  - Otherwise increment counter. When counter reaches TIMEOUT with no done: rsp_result=0, rsp_err=1, go to RESP.
  - If done and the TIMEOUT cycle coincide, done wins.
- RESP:
  - rsp_valid=1; rsp_result, rsp_err and rsp_sel stay stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: rsp_valid falls next cycle, go to IDLE.
  - rsp_result, rsp_err and rsp_sel hold their values after the handshake until the next capture.
  - A new request cannot be accepted in the same cycle as the response handshake.
- fu_a/fu_b hold their value from accept until the next accepted request.
- Latency:
  - Accept at edge N → fu_start high during cycle N+1.
  - Earliest done sample is edge N+2 → rsp_valid from cycle N+3.
  - Illegal select: rsp_valid from cycle N+1.
- Throughput: at most one operation per (4 + unit latency) cycles.
- Counter width: clog2(TIMEOUT+1). The counter does not wrap because it stops at TIMEOUT.

Test Plan:
- Reset mid-WAIT (sel=2, rst_n low for 1 cycle) → all outputs 0, state IDLE, no fu_start pulse after release, next request is processed normally.
- Legal op (SIZE=3): req sel=3, a=5, b=2; unit 3 raises done 2 cycles after its start with slice=5'b00111 → fu_a=5, fu_b=2; fu_start=8'b00001000 for exactly 1 cycle; rsp_valid with rsp_result=7, rsp_err=0, rsp_sel=3.
- Illegal select: req sel=4'b1010 → fu_start stays 0; rsp_valid the cycle after accept with rsp_result=0, rsp_err=1, rsp_sel=10.
- Wrong-unit done: sel=1, fu_done=8'b00000100 held, bit 1 never set → ignored; after TIMEOUT=15 WAIT cycles rsp_err=1, rsp_result=0.
- Backpressure: rsp_ready held low for 5 cycles in RESP → rsp_result/rsp_err/rsp_sel stable, req_ready=0, a concurrent req_valid is not accepted. rsp_ready=1 → IDLE next cycle, the pending request is accepted.
- Done on the timeout boundary: fu_done[sel] asserted on the TIMEOUT-th WAIT cycle → result captured, rsp_err=0.
